afu_wr_commit_gen: RTL and testbench
====================================

Name: afu_wr_commit_gen

Overview:
- FIM-side generator of the local write commits that every AFU receives on its RX B port.
- Passively taps one port's TX A AXI-S stream after TX A/TX B arbitration.
- Detects memory-write TLPs and, after each write's tlast handshake, emits a single-beat Cpl (no data) on RX B carrying the write's tag.
- One instance per port, between the PF/VF mux tree and the port gasket.

Parameters:
- TDATA_W, 512, TX A / RX B tdata width in bits; must be >= 256.
- DEPTH, 16, commit FIFO entries; power of 2, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the pending-commit count.

Ports:
- clk  in  1  port clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_a_tvalid  in  1  tapped TX A valid.
- tx_a_tready  in  1  tapped TX A ready; this block never drives it.
- tx_a_tdata  in  TDATA_W  tapped TX A data.
- tx_a_tlast  in  1  tapped TX A end of packet.
- rx_b_tvalid  out  1  commit valid.
- rx_b_tready  in  1  commit ready from the AFU.
- rx_b_tdata  out  TDATA_W  commit Cpl header; upper bits are zero.
- rx_b_tkeep  out  TDATA_W/8  byte enables; low 32 bytes = 1, all others = 0.
- rx_b_tlast  out  1  always 1 while rx_b_tvalid is high.
- pending_cnt  out  CNT_W  number of entries in the FIFO plus the output register.
- overflow  out  1  sticky flag: a commit was dropped.

Behaviour:
- Beat definition: a TX A beat is one cycle with tx_a_tvalid & tx_a_tready.
- SOP tracking:
  - Internal flag in_pkt, reset 0.
  - SOP beat = beat while in_pkt == 0.
  - in_pkt <= 1 on a beat with tlast == 0; in_pkt <= 0 on a beat with tlast == 1.
- Header decode (SOP beat only):
  - fmt_type = tdata[31:24].
  - Write when fmt_type == 8'h40 (MWr32) or 8'h60 (MWr64); any other value is not a write.
  - tag[9:0] = {tdata[23], tdata[19], tdata[47:40]}.
  - pfvf[14:0] = tdata[174:160].
  - On a write SOP, latch {tag, pfvf} and set is_wr; on a non-write SOP, clear is_wr.
- Push rule:
  - Push {tag, pfvf} on the tlast beat of a write packet.
  - A single-beat write (SOP and tlast on the same beat) pushes the fields decoded from that same beat.
  - At most one push per cycle.
- Commit beat format:
  - tdata[31:24] = 8'h0A (Cpl without data).
  - Tag bits are placed at the same positions they were decoded from.
  - tdata[174:160] = pfvf.
  - All other bits = 0.
- FIFO and output:
  - FIFO is DEPTH deep, followed by a registered output stage.
  - Latency: a push in cycle N with FIFO and output empty gives rx_b_tvalid = 1 in cycle N+1.
  - Back-to-back single-beat writes with rx_b_tready held at 1 give one commit per cycle.
  - rx_b_tvalid and rx_b_tdata stay stable until rx_b_tready; no bubble between consecutive entries.
- Simultaneous push and pop:
  - Both take effect; pending_cnt is unchanged.
  - The full condition is evaluated after the pop, so a push into a full FIFO that pops in the same cycle is accepted.
- Full:
  - A push with no free entry is dropped; the FIFO is unchanged.
  - overflow <= 1 and stays set until reset.
- Counter: pending_cnt saturates structurally at DEPTH+1; no wrap.
- Pointers: wrap modulo DEPTH; full/empty distinguished by an extra pointer MSB.
- Reset (asynchronous, any time including mid-packet):
  - rx_b_tvalid = 0, pending_cnt = 0, overflow = 0, in_pkt = 0, is_wr = 0, FIFO empty.
  - rx_b_tdata = 0, rx_b_tkeep = 0, rx_b_tlast = 0.
  - A packet in flight at reset deassertion is treated from its next beat as SOP. Upstream guarantees the port is quiesced.
- Stall tolerance:
  - tx_a_tvalid high with tx_a_tready low is not a beat; no state changes.
  - Idle gaps inside a packet are tolerated.

Test Plan:
- Single-beat MWr64, tag 10'h2A5, pfvf 15'h0103, rx_b_tready = 1 -> next cycle one rx_b beat with tdata[31:24] = 8'h0A, tag 10'h2A5 at the decoded bit positions, tdata[174:160] = 15'h0103, tlast = 1, low 32 tkeep bytes set; pending_cnt goes 1 then 0.
- 4-beat MWr32, tag 8'h11, tx_a_tready toggling -> no commit until the cycle after the tlast beat; then exactly one commit with tag 8'h11.
- Interleaved MRd (8'h20), MWr (tags 1, 2), Cpl traffic -> exactly two commits, tags 1 then 2, in order; the reads produce none.
- rx_b_tready = 0, DEPTH+3 single-beat writes -> pending_cnt = DEPTH+1, overflow = 1; release ready -> the first DEPTH+1 tags drain in order, the remaining 2 are lost.
- With a full FIFO, a pop and a push in the same cycle -> push accepted; overflow stays 0.
- Assert rst_n = 0 mid-packet and with 3 commits queued -> outputs immediately 0; after release, the next write SOP is decoded correctly and produces one commit.

Source files
------------

// File: rtl/afu_wr_commit_gen_if.sv
// Stream bundle between a port's tapped TX A channel and its RX B commit channel.
// The commit generator uses the master side; the environment uses the slave side.
interface afu_wr_commit_gen_if #(
    parameter int TDATA_W = 512
);
    logic                   tx_a_tvalid;
    logic                   tx_a_tready;
    logic [TDATA_W-1:0]     tx_a_tdata;
    logic                   tx_a_tlast;
    logic                   rx_b_tvalid;
    logic                   rx_b_tready;
    logic [TDATA_W-1:0]     rx_b_tdata;
    logic [TDATA_W/8-1:0]   rx_b_tkeep;
    logic                   rx_b_tlast;

    modport master (
        input  tx_a_tvalid, tx_a_tready, tx_a_tdata, tx_a_tlast, rx_b_tready,
        output rx_b_tvalid, rx_b_tdata, rx_b_tkeep, rx_b_tlast
    );

    modport slave (
        output tx_a_tvalid, tx_a_tready, tx_a_tdata, tx_a_tlast, rx_b_tready,
        input  rx_b_tvalid, rx_b_tdata, rx_b_tkeep, rx_b_tlast
    );
endinterface

// File: rtl/afu_wr_commit_gen.sv
// Taps a port's arbitrated TX A stream, spots memory writes and returns one
// no-data Cpl per write on RX B, through a FIFO plus a registered output stage.
module afu_wr_commit_gen #(
    parameter int TDATA_W = 512,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    afu_wr_commit_gen_if.master  bus,
    output logic [CNT_W-1:0]     pending_cnt,
    output logic                 overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 25;  // {tag[9:0], pfvf[14:0]}

    logic            in_pkt_q, in_pkt_d;
    logic            is_wr_q, is_wr_d;
    logic [EW-1:0]   entry_q, entry_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic            out_valid_q, out_valid_d;
    logic [EW-1:0]   out_entry_q, out_entry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic            beat_s, sop_s, dec_wr_s, cur_wr_s, push_s;
    logic [7:0]      fmt_s;
    logic [EW-1:0]   dec_entry_s, cur_entry_s;
    logic            fifo_empty_s, fifo_full_s, out_free_s, fifo_rd_s;
    logic            bypass_s, fifo_wr_s, accept_s, pop_out_s;

    // Beat qualification and SOP header decode
    always_comb begin
        beat_s      = bus.tx_a_tvalid & bus.tx_a_tready;
        sop_s       = beat_s & ~in_pkt_q;
        fmt_s       = bus.tx_a_tdata[31:24];
        dec_wr_s    = (fmt_s == 8'h40) || (fmt_s == 8'h60);
        dec_entry_s = {bus.tx_a_tdata[23], bus.tx_a_tdata[19], bus.tx_a_tdata[47:40],
                       bus.tx_a_tdata[174:160]};
        if (sop_s) begin
            cur_wr_s    = dec_wr_s;
            cur_entry_s = dec_entry_s;
        end else begin
            cur_wr_s    = is_wr_q;
            cur_entry_s = entry_q;
        end
        push_s = beat_s & bus.tx_a_tlast & cur_wr_s;
    end

    // FIFO/output-stage flow control; room is judged after this cycle's pop
    always_comb begin
        fifo_empty_s = (wr_ptr_q == rd_ptr_q);
        fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_out_s    = out_valid_q & bus.rx_b_tready;
        out_free_s   = ~out_valid_q | bus.rx_b_tready;
        fifo_rd_s    = out_free_s & ~fifo_empty_s;
        bypass_s     = push_s & out_free_s & fifo_empty_s;
        fifo_wr_s    = push_s & ~bypass_s & (~fifo_full_s | fifo_rd_s);
        accept_s     = bypass_s | fifo_wr_s;
    end

    // Next-state for packet tracking, pointers, output stage and counters
    always_comb begin
        in_pkt_d    = in_pkt_q;
        is_wr_d     = is_wr_q;
        entry_d     = entry_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_entry_d = out_entry_q;
        ovf_d       = ovf_q;
        if (beat_s) begin
            in_pkt_d = ~bus.tx_a_tlast;
        end else begin
            in_pkt_d = in_pkt_q;
        end
        if (sop_s) begin
            is_wr_d = dec_wr_s;
            entry_d = dec_entry_s;
        end else begin
            is_wr_d = is_wr_q;
            entry_d = entry_q;
        end
        if (fifo_wr_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (fifo_rd_s) begin
            rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            out_valid_d = 1'b1;
            out_entry_d = mem_q[rd_ptr_q[AW-1:0]];
        end else if (bypass_s) begin
            out_valid_d = 1'b1;
            out_entry_d = cur_entry_s;
        end else if (out_free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (push_s && !accept_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        cnt_d = cnt_q + CNT_W'(accept_s) - CNT_W'(pop_out_s);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt_q    <= 1'b0;
            is_wr_q     <= 1'b0;
            entry_q     <= {EW{1'b0}};
            wr_ptr_q    <= {(AW+1){1'b0}};
            rd_ptr_q    <= {(AW+1){1'b0}};
            out_valid_q <= 1'b0;
            out_entry_q <= {EW{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            in_pkt_q    <= in_pkt_d;
            is_wr_q     <= is_wr_d;
            entry_q     <= entry_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Commit storage; contents are meaningful only between the pointers
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cur_entry_s;
        end
    end

    // Cpl beat assembled from the output stage; all zero while idle
    always_comb begin
        bus.rx_b_tdata = {TDATA_W{1'b0}};
        bus.rx_b_tkeep = {(TDATA_W/8){1'b0}};
        if (out_valid_q) begin
            bus.rx_b_tdata[31:24]   = 8'h0A;
            bus.rx_b_tdata[23]      = out_entry_q[24];
            bus.rx_b_tdata[19]      = out_entry_q[23];
            bus.rx_b_tdata[47:40]   = out_entry_q[22:15];
            bus.rx_b_tdata[174:160] = out_entry_q[14:0];
            bus.rx_b_tkeep[31:0]    = {32{1'b1}};
        end else begin
            bus.rx_b_tdata = {TDATA_W{1'b0}};
            bus.rx_b_tkeep = {(TDATA_W/8){1'b0}};
        end
        bus.rx_b_tvalid = out_valid_q;
        bus.rx_b_tlast  = out_valid_q;
    end

    assign pending_cnt = cnt_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_afu_wr_commit_gen.sv
// Directed bench for afu_wr_commit_gen: packet-level queue model checked every
// cycle, plus literal expectations on the key scenarios.
module tb_afu_wr_commit_gen;
    localparam int TDATA_W = 512;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic [CNT_W-1:0] pending_cnt;
    logic overflow;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    afu_wr_commit_gen_if #(.TDATA_W(TDATA_W)) bus ();

    afu_wr_commit_gen #(.TDATA_W(TDATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .pending_cnt(pending_cnt), .overflow(overflow)
    );

    logic [TDATA_W/8-1:0] keep_exp = {{(TDATA_W/8-32){1'b0}}, {32{1'b1}}};
    logic [TDATA_W-1:0] junk = {16{32'hDEADBEEF}};

    function automatic logic [TDATA_W-1:0] mk(input logic [7:0] fmt, input logic [9:0] tag,
                                             input logic [14:0] pf);
        logic [TDATA_W-1:0] d;
        d = '0;
        d[31:24]   = fmt;
        d[23]      = tag[9];
        d[19]      = tag[8];
        d[47:40]   = tag[7:0];
        d[174:160] = pf;
        return d;
    endfunction

    function automatic logic [24:0] fields(input logic [TDATA_W-1:0] d);
        return {d[23], d[19], d[47:40], d[174:160]};
    endfunction

    task automatic chk(input string nm, input logic [TDATA_W-1:0] act,
                       input logic [TDATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Packet-level model: queue of commits with room for DEPTH+1 entries
    logic [24:0] mq[$];
    bit m_ovf, m_in_pkt;
    logic [TDATA_W-1:0] m_sop;
    initial begin
        m_ovf = 0; m_in_pkt = 0; m_sop = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete(); m_ovf = 0; m_in_pkt = 0;
            end else begin
                if (mq.size() > 0 && bus.rx_b_tready) void'(mq.pop_front());
                if (bus.tx_a_tvalid && bus.tx_a_tready) begin
                    if (!m_in_pkt) m_sop = bus.tx_a_tdata;
                    if (bus.tx_a_tlast && (m_sop[31:24] == 8'h40 || m_sop[31:24] == 8'h60)) begin
                        if (mq.size() < DEPTH + 1) mq.push_back(fields(m_sop));
                        else m_ovf = 1;
                    end
                    m_in_pkt = !bus.tx_a_tlast;
                end
            end
        end
    end

    // Per-cycle compare against the model, and a log of accepted commit tags
    logic [9:0] seen[$];
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_valid", bus.rx_b_tvalid, 0);
                chk("rst_pending", pending_cnt, 0);
                chk("rst_overflow", overflow, 0);
                chk("rst_tdata", bus.rx_b_tdata, 0);
            end else begin
                chk("valid", bus.rx_b_tvalid, mq.size() > 0);
                chk("pending", pending_cnt, mq.size());
                chk("overflow", overflow, m_ovf);
                if (mq.size() > 0) begin
                    chk("tdata", bus.rx_b_tdata, mk(8'h0A, mq[0][24:15], mq[0][14:0]));
                    chk("tkeep", bus.rx_b_tkeep, keep_exp);
                    chk("tlast", bus.rx_b_tlast, 1);
                end
                if (bus.rx_b_tvalid && bus.rx_b_tready)
                    seen.push_back({bus.rx_b_tdata[23], bus.rx_b_tdata[19], bus.rx_b_tdata[47:40]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [TDATA_W-1:0] d, input logic last, input int stall);
        bus.tx_a_tvalid = 1'b1;
        bus.tx_a_tdata  = d;
        bus.tx_a_tlast  = last;
        bus.tx_a_tready = 1'b0;
        repeat (stall) tick();
        bus.tx_a_tready = 1'b1;
        tick();
        bus.tx_a_tvalid = 1'b0;
        bus.tx_a_tready = 1'b0;
        bus.tx_a_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.tx_a_tvalid = 1'b0; bus.tx_a_tready = 1'b0; bus.tx_a_tlast = 1'b0;
        bus.tx_a_tdata = '0; bus.rx_b_tready = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("reset_tvalid", bus.rx_b_tvalid, 0);
        chk("reset_tkeep", bus.rx_b_tkeep, 0);
        chk("reset_tlast", bus.rx_b_tlast, 0);
        rst_n = 1'b1;
        tick();

        // Single-beat MWr64
        beat(mk(8'h60, 10'h2A5, 15'h0103), 1'b1, 0);
        chk("t1_valid", bus.rx_b_tvalid, 1);
        chk("t1_fmt", bus.rx_b_tdata[31:24], 8'h0A);
        chk("t1_tag", {bus.rx_b_tdata[23], bus.rx_b_tdata[19], bus.rx_b_tdata[47:40]}, 10'h2A5);
        chk("t1_pfvf", bus.rx_b_tdata[174:160], 15'h0103);
        chk("t1_tkeep", bus.rx_b_tkeep, 64'h0000_0000_FFFF_FFFF);
        chk("t1_tlast", bus.rx_b_tlast, 1);
        chk("t1_pend1", pending_cnt, 1);
        tick();
        chk("t1_pend0", pending_cnt, 0);
        chk("t1_idle", bus.rx_b_tvalid, 0);

        // 4-beat MWr32 with stalls and an idle gap
        beat(mk(8'h40, 10'h011, 15'h0022), 1'b0, 1);
        chk("t2_b1", bus.rx_b_tvalid, 0);
        tick();
        beat(junk, 1'b0, 2);
        beat(junk, 1'b0, 0);
        chk("t2_b3", bus.rx_b_tvalid, 0);
        beat(junk, 1'b1, 3);
        chk("t2_valid", bus.rx_b_tvalid, 1);
        chk("t2_tag", {bus.rx_b_tdata[23], bus.rx_b_tdata[19], bus.rx_b_tdata[47:40]}, 10'h011);
        tick(); tick();

        // Interleaved reads, writes and completions
        seen.delete();
        beat(mk(8'h20, 10'h005, 15'h1), 1'b1, 0);
        beat(mk(8'h40, 10'h001, 15'h1), 1'b1, 0);
        beat(mk(8'h4A, 10'h007, 15'h1), 1'b0, 0);
        beat(mk(8'h40, 10'h009, 15'h9), 1'b1, 0);
        beat(mk(8'h60, 10'h002, 15'h2), 1'b0, 0);
        beat(junk, 1'b1, 1);
        beat(mk(8'h20, 10'h003, 15'h3), 1'b0, 0);
        beat(mk(8'h60, 10'h004, 15'h4), 1'b1, 0);
        repeat (3) tick();
        chk("t3_count", seen.size(), 2);
        chk("t3_first", seen[0], 10'h001);
        chk("t3_second", seen[1], 10'h002);

        // Overflow with output stalled
        bus.rx_b_tready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) beat(mk(8'h60, 10'(100 + i), 15'(i)), 1'b1, 0);
        chk("t4_pending", pending_cnt, DEPTH + 1);
        chk("t4_overflow", overflow, 1);
        seen.delete();
        bus.rx_b_tready = 1'b1;
        repeat (DEPTH + 4) tick();
        chk("t4_drained", seen.size(), DEPTH + 1);
        for (int i = 0; i < DEPTH + 1; i++) chk("t4_order", seen[i], 10'(100 + i));
        chk("t4_sticky", overflow, 1);

        // Full FIFO: pop and push in the same cycle
        do_reset();
        bus.rx_b_tready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) beat(mk(8'h40, 10'(200 + i), 15'(i)), 1'b1, 0);
        chk("t5_full", pending_cnt, DEPTH + 1);
        chk("t5_noovf", overflow, 0);
        bus.rx_b_tready = 1'b1;
        beat(mk(8'h40, 10'h3C3, 15'h0555), 1'b1, 0);
        chk("t5_pending", pending_cnt, DEPTH + 1);
        chk("t5_overflow", overflow, 0);
        repeat (DEPTH + 3) tick();
        chk("t5_empty", pending_cnt, 0);

        // Asynchronous reset mid-packet with commits queued
        bus.rx_b_tready = 1'b0;
        for (int i = 0; i < 3; i++) beat(mk(8'h60, 10'(300 + i), 15'(i)), 1'b1, 0);
        beat(mk(8'h60, 10'h155, 15'h0AAA), 1'b0, 0);
        chk("t6_queued", pending_cnt, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid0", bus.rx_b_tvalid, 0);
        chk("t6_pend0", pending_cnt, 0);
        chk("t6_tdata0", bus.rx_b_tdata, 0);
        chk("t6_tkeep0", bus.rx_b_tkeep, 0);
        chk("t6_tlast0", bus.rx_b_tlast, 0);
        tick(); tick();
        rst_n = 1'b1;
        bus.rx_b_tready = 1'b1;
        tick();
        beat(mk(8'h60, 10'h3FF, 15'h7FFF), 1'b0, 0);
        chk("t6_nocommit", bus.rx_b_tvalid, 0);
        beat(junk, 1'b1, 0);
        chk("t6_valid", bus.rx_b_tvalid, 1);
        chk("t6_tag", {bus.rx_b_tdata[23], bus.rx_b_tdata[19], bus.rx_b_tdata[47:40]}, 10'h3FF);
        chk("t6_pfvf", bus.rx_b_tdata[174:160], 15'h7FFF);
        tick();
        chk("t6_done", pending_cnt, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
